// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the controller state encoding and the iteration-counter sizing rule.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..width-1; a 1-bit floor keeps tiny widths legal.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/addsub_n.sv
// WIDTH-bit adder/subtractor: Sum = A + B, or A - B computed as A + ~B + 1.
module addsub_n #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic [WIDTH-1:0] Sum
);

    logic [WIDTH-1:0] b_op;

    assign b_op = Sub ? ~B : B;
    assign Sum  = A + b_op + WIDTH'(Sub);

endmodule

// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier, one multiplier bit per clock, signed or unsigned.
// B holds the multiplier and collects the low product; {X,A} collect the high product.
module seq_multiplier_n #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] S,
    output logic             X,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done
);
    import mult_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] m_reg;
    logic             mode;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH:0]   a_ext, m_ext, addend, sum;
    logic             sub;

    assign last = (cnt == CW'(WIDTH - 1));

    // NOTE: registers update with <= so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Run && !ClearA_LoadB) state_nxt = CALC;
            CALC:    if (last)                 state_nxt = DONE;
            DONE:    if (!Run)                 state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    assign Busy = (state == CALC);
    assign Done = (state == DONE);

    // Extended operands; the multiplier sign bit carries negative weight on the last step.
    assign a_ext  = mode ? {A[WIDTH-1], A} : {1'b0, A};
    assign m_ext  = mode ? {m_reg[WIDTH-1], m_reg} : {1'b0, m_reg};
    assign addend = B[0] ? m_ext : '0;
    assign sub    = B[0] & mode & last;

    addsub_n #(
        .WIDTH(WIDTH + 1)
    ) u_addsub (
        .A  (a_ext),
        .B  (addend),
        .Sub(sub),
        .Sum(sum)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            X     <= 1'b0;
            A     <= '0;
            B     <= '0;
            m_reg <= '0;
            mode  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ClearA_LoadB) begin
                        B <= S;
                        A <= '0;
                        X <= 1'b0;
                    end else if (Run) begin
                        m_reg <= S;
                        mode  <= Signed_Mode;
                        A     <= '0;
                        X     <= 1'b0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    X   <= mode ? sum[WIDTH] : 1'b0;
                    A   <= sum[WIDTH:1];
                    B   <= {sum[0], B[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Directed bench for seq_multiplier_n (WIDTH=8): handshake timing, signed/unsigned
// products, chaining, input isolation during CALC, and mid-operation reset.
module tb_seq_multiplier_n;

    logic       Clk = 1'b0;
    logic       Reset, Run, ClearA_LoadB, Signed_Mode;
    logic [7:0] S;
    logic       X;
    logic [7:0] A, B;
    logic       Busy, Done;

    int checks   = 0;
    int failures = 0;

    seq_multiplier_n #(.WIDTH(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Run         (Run),
        .ClearA_LoadB(ClearA_LoadB),
        .Signed_Mode (Signed_Mode),
        .S           (S),
        .X           (X),
        .A           (A),
        .B           (B),
        .Busy        (Busy),
        .Done        (Done)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_b(input string tag, input logic [7:0] v);
        ClearA_LoadB = 1'b1;
        Run          = 1'b0;
        S            = v;
        step();
        ClearA_LoadB = 1'b0;
        check({tag, "_load_B"}, 32'(B), 32'(v));
        check({tag, "_load_A"}, 32'(A), 32'h0);
    endtask

    // Start a multiply, wait (bounded) for Done, check product and handshake timing.
    task automatic run_mult(input string tag, input logic [7:0] s, input logic sm,
                            input logic [15:0] exp_prod, input logic exp_x,
                            input bit disturb, input bit hold_run);
        int cycles;
        int busy_cnt;
        S            = s;
        Signed_Mode  = sm;
        ClearA_LoadB = 1'b0;
        Run          = 1'b1;
        step();
        check({tag, "_busy_start"}, 32'(Busy), 32'h1);
        if (!hold_run) Run = 1'b0;
        cycles   = 0;
        busy_cnt = 0;
        while (!Done && cycles < 40) begin
            if (Busy) busy_cnt++;
            if (disturb) begin
                if (cycles == 2) begin
                    ClearA_LoadB = 1'b1;
                    S            = ~s;
                    Signed_Mode  = ~sm;
                end else if (cycles == 4) begin
                    ClearA_LoadB = 1'b0;
                end
            end
            step();
            cycles++;
        end
        check({tag, "_cycles_to_done"}, 32'(cycles), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_product"}, 32'({A, B}), 32'(exp_prod));
        check({tag, "_x"}, 32'(X), 32'(exp_x));
        if (hold_run) begin
            for (int i = 0; i < 3; i++) begin
                step();
                check({tag, "_hold_done"}, 32'(Done), 32'h1);
                check({tag, "_hold_busy"}, 32'(Busy), 32'h0);
                check({tag, "_hold_product"}, 32'({A, B}), 32'(exp_prod));
            end
            Run = 1'b0;
        end
        step();
        check({tag, "_idle_done"}, 32'(Done), 32'h0);
        check({tag, "_idle_busy"}, 32'(Busy), 32'h0);
        Signed_Mode = sm;
    endtask

    initial begin
        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        Signed_Mode  = 1'b0;
        S            = 8'h00;
        step();
        step();
        Reset = 1'b0;
        check("reset_X", 32'(X), 32'h0);
        check("reset_AB", 32'({A, B}), 32'h0);
        check("reset_busy", 32'(Busy), 32'h0);
        check("reset_done", 32'(Done), 32'h0);

        // 7 * 59 = 413, Run held high through DONE
        load_b("s1", 8'h07);
        run_mult("s1", 8'h3B, 1'b1, 16'h019D, 1'b0, 1'b0, 1'b1);

        // Chained: B = 0x9D (-99) * 2 = -198
        run_mult("s4", 8'h02, 1'b1, 16'hFF3A, 1'b1, 1'b0, 1'b0);

        // -7 * 59 = -413
        load_b("s2", 8'hF9);
        run_mult("s2", 8'h3B, 1'b1, 16'hFE63, 1'b1, 1'b0, 1'b0);

        // -128 * -128 = 16384, final-step subtract
        load_b("s3s", 8'h80);
        run_mult("s3s", 8'h80, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);

        // 255 * 255 unsigned = 65025
        load_b("s3u", 8'hFF);
        run_mult("s3u", 8'hFF, 1'b0, 16'hFE01, 1'b0, 1'b0, 1'b0);

        // 12 * 10 unsigned while ClearA_LoadB, S and Signed_Mode toggle during CALC
        load_b("s5d", 8'h0C);
        run_mult("s5d", 8'h0A, 1'b0, 16'h0078, 1'b0, 1'b1, 1'b0);

        // ClearA_LoadB and Run together: load only, start next cycle; 5 * 3
        ClearA_LoadB = 1'b1;
        Run          = 1'b1;
        S            = 8'h05;
        step();
        check("s5b_no_start", 32'(Busy), 32'h0);
        check("s5b_loaded", 32'(B), 32'h05);
        run_mult("s5b", 8'h03, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0);

        // Reset during 4th CALC cycle, then a fresh 19 * 11
        load_b("s6", 8'h13);
        S           = 8'h0B;
        Signed_Mode = 1'b0;
        Run         = 1'b1;
        step();
        Run = 1'b0;
        step();
        step();
        step();
        check("s6_busy_before_reset", 32'(Busy), 32'h1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("s6_reset_X", 32'(X), 32'h0);
        check("s6_reset_AB", 32'({A, B}), 32'h0);
        check("s6_reset_busy", 32'(Busy), 32'h0);
        check("s6_reset_done", 32'(Done), 32'h0);
        step();
        check("s6_stays_idle", 32'(Busy), 32'h0);
        load_b("s6r", 8'h13);
        run_mult("s6r", 8'h0B, 1'b0, 16'h00D1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
